// File: rtl/tech_ram_req_bridge.sv
// tech_ram_req_bridge: valid/ready front end for the single-port RAM macro.
// Drives the active-low macro controls straight from the request, captures the
// 1-cycle-latency read data and returns it through a credit-managed FIFO.
module tech_ram_req_bridge #(
  parameter  int unsigned BIT_WIDTH  = 128,
  parameter  int unsigned WORD_DEPTH = 64,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW         = $clog2(WORD_DEPTH),
  localparam int unsigned BMW        = BIT_WIDTH / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AW-1:0]        req_addr_i,
  input  logic [BMW-1:0]       req_bm_i,
  input  logic [BIT_WIDTH-1:0] req_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [BIT_WIDTH-1:0] rsp_dat_o,
  output logic                 ram_en_o,
  output logic                 ram_wen_o,
  output logic [BMW-1:0]       ram_bm_o,
  output logic [AW-1:0]        ram_addr_o,
  output logic [BIT_WIDTH-1:0] ram_dat_o,
  input  logic [BIT_WIDTH-1:0] ram_dat_i
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic [BIT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        fifo_cnt;
  logic                 rd_pend;
  logic [OW-1:0]        occ;
  logic                 fire;
  logic                 wr_fire;
  logic                 rd_fire;
  logic                 push;
  logic                 pop;

  // Credit: an in-flight read already owns a FIFO slot, so ready looks only at registers.
  assign occ         = OW'(rd_pend) + OW'(fifo_cnt);
  assign req_ready_o = rst_n_i & (occ < OW'(FIFO_DEPTH));

  assign fire    = req_valid_i & req_ready_o;
  assign wr_fire = fire & req_we_i;
  assign rd_fire = fire & ~req_we_i;
  assign push    = rd_pend;
  assign pop     = rsp_valid_o & rsp_ready_i;

  // Macro drive is combinational so the access happens at the request's fire edge.
  assign ram_en_o   = ~fire;
  assign ram_wen_o  = ~wr_fire;
  assign ram_bm_o   = wr_fire ? req_bm_i : '1;
  assign ram_addr_o = req_addr_i;
  assign ram_dat_o  = req_dat_i;

  assign rsp_valid_o = (fifo_cnt != '0);
  assign rsp_dat_o   = fifo_mem[rd_ptr];

  // Read-pending flag plus circular response buffer; macro data is taken only while rd_pend is set.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_pend  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[PW'(i)] <= '0;
      end
    end else begin
      rd_pend <= rd_fire;
      if (push) begin
        fifo_mem[wr_ptr] <= ram_dat_i;
        wr_ptr           <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

endmodule
